// File: rtl/sorted_insert_ctrl.sv
// Sorted-list builder: inserts keys via an external right-shift stage, then drains ascending. Optional SORTED_INSERT_DUP_DROP_EN drops duplicate keys.
// Latency: one key per 2 cycles (accept, insert); drain emits one entry per cycle while out_ready is high.
// Backpressure: in_ready only in ACCEPT; drain holds out_data/out_last stable while out_ready is low.
module sorted_insert_ctrl #(
    parameter int data_width_param   = 32,
    parameter int max_elements_param = 16,
    parameter int idx_width_param    = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [data_width_param-1:0]                  in_key,
    input  logic                                         in_last,
    output logic [max_elements_param*data_width_param-1:0] shift_arr,
    output logic [idx_width_param-1:0]                   shift_idx,
    output logic [data_width_param-1:0]                  shift_val,
    input  logic [max_elements_param*data_width_param-1:0] shift_new_arr,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [data_width_param-1:0]                  out_data,
    output logic                                         out_last,
    output logic                                         full_flush
);

    localparam int ARR_W = max_elements_param * data_width_param;
    localparam int CNT_W = idx_width_param + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(max_elements_param);
    localparam logic [idx_width_param-1:0] IDX_ONE = idx_width_param'(1);

    typedef enum logic [1:0] {ACCEPT, INSERT, DRAIN} state_t;

    state_t                       state_q;
    logic [ARR_W-1:0]             arr_q;
    logic [CNT_W-1:0]             count_q;
    logic [idx_width_param-1:0]   rd_ptr_q;
    logic [data_width_param-1:0]  key_q;
    logic                         last_q;
    logic                         full_flush_q;

    logic [data_width_param-1:0]  arr_ent [max_elements_param];
    logic [idx_width_param-1:0]   lt_cnt;
    logic [CNT_W-1:0]             count_inc;

    always_comb begin
        for (int i = 0; i < max_elements_param; i++) begin
            arr_ent[i] = arr_q[ARR_W-1-data_width_param*i -: data_width_param];
        end
    end

    // Only occupied slots take part; stale contents beyond count never bias the index.
    always_comb begin
        lt_cnt = '0;
        for (int j = 0; j < max_elements_param; j++) begin
            if ((CNT_W'(j) < count_q) && (arr_ent[j] < key_q)) begin
                lt_cnt = lt_cnt + IDX_ONE;
            end
        end
    end

`ifdef SORTED_INSERT_DUP_DROP_EN
    logic dup_hit;
    always_comb begin
        dup_hit = 1'b0;
        for (int j = 0; j < max_elements_param; j++) begin
            if ((CNT_W'(j) < count_q) && (arr_ent[j] == key_q)) begin
                dup_hit = 1'b1;
            end
        end
    end
`endif

    assign count_inc  = count_q + CNT_ONE;
    assign in_ready   = (state_q == ACCEPT);
    assign out_valid  = (state_q == DRAIN);
    assign out_data   = out_valid ? arr_ent[rd_ptr_q] : '0;
    assign out_last   = out_valid && ({1'b0, rd_ptr_q} == (count_q - CNT_ONE));
    assign shift_arr  = arr_q;
    assign shift_idx  = (state_q == INSERT) ? lt_cnt : '0;
    assign shift_val  = (state_q == INSERT) ? key_q : '0;
    assign full_flush = full_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACCEPT;
            arr_q        <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            key_q        <= '0;
            last_q       <= 1'b0;
            full_flush_q <= 1'b0;
        end else begin
            full_flush_q <= 1'b0;
            case (state_q)
                ACCEPT: begin
                    if (in_valid) begin
                        key_q   <= in_key;
                        last_q  <= in_last;
                        state_q <= INSERT;
                    end
                end
                INSERT: begin
`ifdef SORTED_INSERT_DUP_DROP_EN
                    if (dup_hit) begin
                        state_q <= last_q ? DRAIN : ACCEPT;
                    end else
`endif
                    begin
                        arr_q   <= shift_new_arr;
                        count_q <= count_inc;
                        if (last_q || (count_inc == CNT_MAX)) begin
                            state_q      <= DRAIN;
                            full_flush_q <= !last_q;
                        end else begin
                            state_q <= ACCEPT;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            count_q  <= '0;
                            rd_ptr_q <= '0;
                            arr_q    <= '0;
                            state_q  <= ACCEPT;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + IDX_ONE;
                        end
                    end
                end
                default: state_q <= ACCEPT;
            endcase
        end
    end

endmodule
